// File: rtl/alu_serial_rx.sv
// alu_serial_rx: receiver for the ALU serial command link.
// A frame is 8 data packets (B bytes then A bytes, MSB first) followed by one
// control packet carrying op and a CRC-4. Each packet is 11 bits:
// start '0', type ('0' data / '1' control), 8 payload bits, stop '1'.
// Ports:
//   clk       - clock, sin sampled on every posedge
//   rst_n     - asynchronous active-low reset
//   sin       - serial input, idles at 1
//   out_valid - one-cycle pulse when a frame completes
//   out_b     - operand B (first byte received is [31:24])
//   out_a     - operand A (first byte received is [31:24])
//   out_op    - op field from the control packet
//   out_err   - {ERR_DATA, ERR_CRC, ERR_OP}, one-hot or zero
//   busy      - high from start-bit detection until out_valid
module alu_serial_rx #(
  parameter logic [3:0] CRC_INIT   = 4'b0000,
  parameter bit         CHECK_STOP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        out_valid,
  output logic [31:0] out_b,
  output logic [31:0] out_a,
  output logic [2:0]  out_op,
  output logic [2:0]  out_err,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_TYPE, S_PAYLOAD, S_STOP} state_t;

  state_t      state_r, state_s;
  logic [2:0]  bit_cnt_r;
  logic [3:0]  pkt_cnt_r;
  logic        is_ctrl_r;
  logic [6:0]  pay_r;      // last 7 payload bits; for control this is {op, crc}
  logic [3:0]  crc_r;
  logic        data_err_r;
  logic [31:0] b_sh_r;
  logic [31:0] a_sh_r;
  logic [2:0]  err_s;

  // One step of the x^4+x+1 LFSR, MSB-first input.
  function automatic logic [3:0] crc_step(input logic [3:0] crc, input logic b);
    logic fb;
    fb = crc[3] ^ b;
    crc_step = {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
  endfunction

  // Packet FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Packet FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:    if (!sin) state_s = S_TYPE; else state_s = S_IDLE;
      S_TYPE:    state_s = S_PAYLOAD;
      S_PAYLOAD: if (bit_cnt_r == 3'd7) state_s = S_STOP; else state_s = S_PAYLOAD;
      S_STOP:    state_s = S_IDLE;
      default:   state_s = S_IDLE;
    endcase
  end

  // Frame classification, evaluated while the control packet's stop bit is on sin.
  // Anything other than exactly 8 data packets, or a bad stop bit, is a data error.
  always_comb begin
    err_s = 3'b000;
    if (data_err_r || (pkt_cnt_r != 4'd8) || (CHECK_STOP && !sin)) begin
      err_s = 3'b100;
    end else if (crc_r != pay_r[3:0]) begin
      err_s = 3'b010;
    end else if (!((pay_r[6:4] == 3'b000) || (pay_r[6:4] == 3'b001) ||
                   (pay_r[6:4] == 3'b100) || (pay_r[6:4] == 3'b101))) begin
      err_s = 3'b001;
    end else begin
      err_s = 3'b000;
    end
  end

  // Deframing datapath, CRC accumulation and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r  <= 3'd0;
      pkt_cnt_r  <= 4'd0;
      is_ctrl_r  <= 1'b0;
      pay_r      <= 7'd0;
      crc_r      <= CRC_INIT;
      data_err_r <= 1'b0;
      b_sh_r     <= 32'd0;
      a_sh_r     <= 32'd0;
      out_valid  <= 1'b0;
      out_b      <= 32'd0;
      out_a      <= 32'd0;
      out_op     <= 3'd0;
      out_err    <= 3'd0;
      busy       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (!sin) begin
            busy <= 1'b1;
            // busy low here means this is the first packet of a new frame
            if (!busy) crc_r <= CRC_INIT;
          end
        end
        S_TYPE: begin
          is_ctrl_r <= sin;
          bit_cnt_r <= 3'd0;
        end
        S_PAYLOAD: begin
          bit_cnt_r <= bit_cnt_r + 3'd1;
          pay_r     <= {pay_r[5:0], sin};
          if (!is_ctrl_r) begin
            crc_r <= crc_step(crc_r, sin);
            if (pkt_cnt_r < 4'd4) begin
              b_sh_r <= {b_sh_r[30:0], sin};
            end else if (pkt_cnt_r < 4'd8) begin
              a_sh_r <= {a_sh_r[30:0], sin};
            end
          end else if (bit_cnt_r == 3'd0) begin
            // The ignored control bit 7 slot carries a constant 1 into the CRC.
            crc_r <= crc_step(crc_r, 1'b1);
          end else if (bit_cnt_r < 3'd4) begin
            crc_r <= crc_step(crc_r, sin);
          end
        end
        S_STOP: begin
          if (!is_ctrl_r) begin
            if (pkt_cnt_r != 4'd15) pkt_cnt_r <= pkt_cnt_r + 4'd1;
            if ((pkt_cnt_r >= 4'd8) || (CHECK_STOP && !sin)) data_err_r <= 1'b1;
          end else begin
            out_valid  <= 1'b1;
            busy       <= 1'b0;
            out_b      <= b_sh_r;
            out_a      <= a_sh_r;
            out_op     <= pay_r[6:4];
            out_err    <= err_s;
            pkt_cnt_r  <= 4'd0;
            data_err_r <= 1'b0;
            crc_r      <= CRC_INIT;
          end
        end
        default: begin
          bit_cnt_r <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_rx.sv
module tb_alu_serial_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b1;
  logic        out_valid;
  logic [31:0] out_b, out_a;
  logic [2:0]  out_op, out_err;
  logic        busy;

  typedef struct packed {
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    logic [2:0]  err;
    logic        full;   // 1: compare operands too, 0: op/err only
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];
  int   total = 0;
  int   passed = 0;

  alu_serial_rx #(.CRC_INIT(4'b0000), .CHECK_STOP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .out_valid(out_valid),
    .out_b(out_b), .out_a(out_a), .out_op(out_op), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: capture every completed frame.
  always @(negedge clk) begin
    res_t r;
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      r.b = out_b; r.a = out_a; r.op = out_op; r.err = out_err; r.full = 1'b1;
      got_q.push_back(r);
    end
  end

  function automatic logic [3:0] golden_crc(input logic [31:0] b, input logic [31:0] a,
                                            input logic [2:0] op);
    logic [67:0] v;
    logic [3:0]  c;
    logic        fb;
    v = {b, a, 1'b1, op};
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ v[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic send_pkt(input logic ctrl, input logic [7:0] payload, input logic stop);
    send_bit(1'b0);
    send_bit(ctrl);
    for (int i = 7; i >= 0; i--) send_bit(payload[i]);
    send_bit(stop);
  endtask

  // ndata data packets (bytes of {B,A} in order), then the control packet.
  task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                            input logic [3:0] crc, input int ndata, input int bad_stop);
    logic [63:0] w;
    w = {b, a};
    for (int i = 0; i < ndata; i++) send_pkt(1'b0, w[63-8*i -: 8], (i == bad_stop) ? 1'b0 : 1'b1);
    send_pkt(1'b1, {1'b0, op, crc}, 1'b1);
  endtask

  task automatic push_exp(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                          input logic [2:0] err, input logic full);
    res_t r;
    r.b = b; r.a = a; r.op = op; r.err = err; r.full = full;
    exp_q.push_back(r);
  endtask

  task automatic wait_got(input int n, input string name);
    int k;
    k = 0;
    sin = 1'b1;
    while (got_q.size() < n && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (got_q.size() < n) begin
      total++;
      $display("FAIL %s timeout: got %0d frames, expected %0d", name, got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, out_a, out_b, out_op, out_err, busy} !== 70'd0)
      $display("FAIL reset_outputs got=%h expected=0", {out_valid, out_a, out_b, out_op, out_err, busy});
    else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_and();
    res_t e, g;
    push_exp(32'h12345678, 32'h9ABCDEF0, 3'b000, 3'b000, 1'b1);
    send_frame(32'h12345678, 32'h9ABCDEF0, 3'b000, golden_crc(32'h12345678, 32'h9ABCDEF0, 3'b000), 8, -1);
    sin = 1'b1;
    total++;
    if (busy !== 1'b1) $display("FAIL and_busy_mid got=%b expected=1", busy); else passed++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1) $display("FAIL and_latency out_valid=%b expected=1", out_valid); else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL and_busy_fall busy=%b expected=0", busy); else passed++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL and_pulse_width out_valid=%b expected=0", out_valid); else passed++;
    wait_got(1, "and");
    if (got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) $display("FAIL and_result got=%h expected=%h", g, e); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    res_t e, g;
    push_exp(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b100, 3'b000, 1'b1);
    push_exp(32'h0000ABCD, 32'h00001234, 3'b101, 3'b000, 1'b1);
    send_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b100, golden_crc(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b100), 8, -1);
    send_frame(32'h0000ABCD, 32'h00001234, 3'b101, golden_crc(32'h0000ABCD, 32'h00001234, 3'b101), 8, -1);
    wait_got(2, "b2b");
    for (int i = 0; i < 2; i++) begin
      if (got_q.size() > 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front();
        total++;
        if (g !== e) $display("FAIL b2b_result%0d got=%h expected=%h", i, g, e); else passed++;
      end
    end
  endtask

  task automatic test_errors();
    res_t e, g;
    logic [3:0] c;
    c = golden_crc(32'h00000002, 32'h00000001, 3'b001) + 4'd1;
    push_exp(32'h00000002, 32'h00000001, 3'b001, 3'b010, 1'b1);
    send_frame(32'h00000002, 32'h00000001, 3'b001, c, 8, -1);
    push_exp(32'h0BADF00D, 32'hCAFEBABE, 3'b110, 3'b001, 1'b1);
    send_frame(32'h0BADF00D, 32'hCAFEBABE, 3'b110, golden_crc(32'h0BADF00D, 32'hCAFEBABE, 3'b110), 8, -1);
    push_exp(32'h13579BDF, 32'h2468ACE0, 3'b111, 3'b001, 1'b1);
    send_frame(32'h13579BDF, 32'h2468ACE0, 3'b111, golden_crc(32'h13579BDF, 32'h2468ACE0, 3'b111), 8, -1);
    // 7 data packets: crc field is also wrong for what was received
    push_exp(32'h0, 32'h0, 3'b100, 3'b100, 1'b0);
    send_frame(32'hA5A5A5A5, 32'h5A5A5A5A, 3'b100, golden_crc(32'hA5A5A5A5, 32'h5A5A5A5A, 3'b100), 7, -1);
    // framing error on data packet 3 with a correct crc
    push_exp(32'h0, 32'h0, 3'b000, 3'b100, 1'b0);
    send_frame(32'h11223344, 32'h55667788, 3'b000, golden_crc(32'h11223344, 32'h55667788, 3'b000), 8, 2);
    // framing error plus wrong crc
    push_exp(32'h0, 32'h0, 3'b001, 3'b100, 1'b0);
    send_frame(32'h11223344, 32'h55667788, 3'b001, ~golden_crc(32'h11223344, 32'h55667788, 3'b001), 8, 5);
    // 9 data packets
    push_exp(32'h0, 32'h0, 3'b000, 3'b100, 1'b0);
    send_pkt(1'b0, 8'h77, 1'b1);
    send_frame(32'h01020304, 32'h05060708, 3'b000, golden_crc(32'h01020304, 32'h05060708, 3'b000), 8, -1);
    wait_got(7, "errors");
    for (int i = 0; i < 7; i++) begin
      if (got_q.size() > 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front();
        total++;
        if (e.full ? (g !== e) : ({g.op, g.err} !== {e.op, e.err}))
          $display("FAIL err_case%0d got=%h expected=%h", i, g, e);
        else passed++;
      end
    end
  endtask

  task automatic test_mid_reset();
    res_t e, g;
    for (int i = 0; i < 5; i++) send_pkt(1'b0, 8'hC3 + 8'(i), 1'b1);
    @(negedge clk);
    sin = 1'b1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_a, out_b, out_op, out_err, busy} !== 70'd0)
      $display("FAIL midreset_outputs got=%h expected=0", {out_valid, out_a, out_b, out_op, out_err, busy});
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (got_q.size() != 0) $display("FAIL midreset_no_valid got=%0d frames expected=0", got_q.size());
    else passed++;
    push_exp(32'h0, 32'h0, 3'b000, 3'b000, 1'b1);
    send_frame(32'h0, 32'h0, 3'b000, golden_crc(32'h0, 32'h0, 3'b000), 8, -1);
    wait_got(1, "post_reset");
    if (got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) $display("FAIL post_reset_result got=%h expected=%h", g, e); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_back_to_back();
    test_errors();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
